// File: rtl/ccsds_pkg.sv
`default_nettype none
// ---- ccsds_pkg : shared ASM, randomizer and FSM constants for the CCSDS framer (rev 1.0) ----
package ccsds_pkg;

  localparam logic [31:0] ASM32     = 32'h1ACFFC1D;
  localparam logic [63:0] ASM64     = 64'h034776C7272895B0;

  // Feedback taps for x^8+x^7+x^5+x^3+1 with the output taken from bit 7.
  localparam logic [7:0]  RAND_TAPS = 8'h95;
  localparam logic [7:0]  RAND_SEED = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ASM  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  function automatic logic lfsr_fb(input logic [7:0] s);
    return ^(s & RAND_TAPS);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ccsds_randomizer_lfsr.sv
`default_nettype none
// ---- ccsds_randomizer_lfsr : CCSDS pseudo-randomizer sequence generator, seed FF (rev 1.0) ----
module ccsds_randomizer_lfsr
  import ccsds_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic init,
  input  logic step,
  output logic rnd
);

  logic [7:0] r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RAND_SEED;
    end else if (init) begin
      r_state <= RAND_SEED;
    end else if (step) begin
      r_state <= {r_state[6:0], lfsr_fb(r_state)};
    end
  end

  assign rnd = r_state[7];

endmodule
`default_nettype wire

// File: rtl/ccsds_asm_randomizer.sv
`default_nettype none
// ---- ccsds_asm_randomizer : prepends the ASM to each codeword and optionally randomizes it (rev 1.0) ----
module ccsds_asm_randomizer
  import ccsds_pkg::*;
#(
  parameter int          ASM_WIDTH   = 64,
  parameter logic [63:0] ASM_PATTERN = ASM64,
  parameter bit          RAND_EN     = 1'b1,
  parameter int          CW_LEN      = 24756
) (
  input  logic clk,
  input  logic rst_n,
  input  logic s_axis_tdata,
  input  logic s_axis_tvalid,
  output logic s_axis_tready,
  input  logic s_axis_tlast,
  output logic m_axis_tdata,
  output logic m_axis_tvalid,
  output logic m_axis_tlast,
  input  logic m_axis_tready,
  output logic len_err
);

  localparam int                CNT_W   = (CW_LEN < 1) ? 1 : $clog2(CW_LEN + 1);
  localparam logic [5:0]        ASM_MSB = 6'(ASM_WIDTH - 1);
  localparam logic [CNT_W:0]    LEN_CHK = (CNT_W + 1)'(CW_LEN);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  state_t           r_state;
  logic [5:0]       r_asm_cnt;
  logic [CNT_W-1:0] r_cw_cnt;

  logic             w_slot_free;
  logic [5:0]       w_asm_idx;
  logic             w_asm_done;
  logic             w_hs;
  logic             w_rnd;
  logic             w_data_bit;
  logic [CNT_W:0]   w_cw_next;

  assign w_slot_free   = !m_axis_tvalid || m_axis_tready;
  assign w_asm_idx     = ASM_MSB - r_asm_cnt;
  assign w_asm_done    = (r_state == ST_ASM) && w_slot_free && (w_asm_idx == 6'd0);
  assign w_hs          = (r_state == ST_DATA) && s_axis_tvalid && w_slot_free;
  assign s_axis_tready = (r_state == ST_DATA) && w_slot_free;
  assign w_data_bit    = s_axis_tdata ^ (RAND_EN & w_rnd);
  assign w_cw_next     = {1'b0, r_cw_cnt} + 1'b1;

  // Reseeded as the last ASM bit is loaded so every codeword starts at FF.
  ccsds_randomizer_lfsr u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .init  (w_asm_done),
    .step  (w_hs),
    .rnd   (w_rnd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_asm_cnt     <= '0;
      r_cw_cnt      <= '0;
      m_axis_tdata  <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      len_err       <= 1'b0;
    end else begin
      len_err <= 1'b0;
      if (w_slot_free) begin
        m_axis_tvalid <= 1'b0;
        m_axis_tlast  <= 1'b0;
        case (r_state)
          ST_IDLE: begin
            // The waiting input beat only triggers the ASM; it is consumed in DATA.
            if (s_axis_tvalid) begin
              m_axis_tdata  <= ASM_PATTERN[ASM_MSB];
              m_axis_tvalid <= 1'b1;
              r_asm_cnt     <= 6'd1;
              r_state       <= ST_ASM;
            end
          end
          ST_ASM: begin
            m_axis_tdata  <= ASM_PATTERN[w_asm_idx];
            m_axis_tvalid <= 1'b1;
            r_asm_cnt     <= r_asm_cnt + 6'd1;
            if (w_asm_idx == 6'd0) begin
              r_cw_cnt <= '0;
              r_state  <= ST_DATA;
            end
          end
          ST_DATA: begin
            if (s_axis_tvalid) begin
              m_axis_tdata  <= w_data_bit;
              m_axis_tlast  <= s_axis_tlast;
              m_axis_tvalid <= 1'b1;
              if (r_cw_cnt != CNT_MAX) begin
                r_cw_cnt <= r_cw_cnt + 1'b1;
              end
              if (s_axis_tlast) begin
                r_state <= ST_IDLE;
                len_err <= (CW_LEN != 0) && (w_cw_next != LEN_CHK);
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ccsds_asm_randomizer.sv
`default_nettype none
// ---- tb_ccsds_asm_randomizer : scoreboard bench for the ASM + randomizer framer (rev 1.0) ----
module tb_ccsds_asm_randomizer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic s_tdata = 1'b0, s_tvalid = 1'b0, s_tlast = 1'b0, m_ready = 1'b1;
  logic tready_a, tdata_a, tvalid_a, tlast_a, len_err_a;
  logic tready_b, tdata_b, tvalid_b, tlast_b, len_err_b;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic a;
    logic b;
    logic last;
    logic cw;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [254:0] rnd_seq;
  logic [31:0] asm_v = 32'h1ACFFC1D;
  bit          rand_ready = 1'b0;
  bit          gap_mode = 1'b0;
  int          beats = 0, last_idx = 0, run_len = 0, run_at_last = 0;
  int          pulses = 0, high_cycles = 0, b_err = 0;
  logic        stalled = 1'b0, held = 1'b0, prev_le = 1'b0;
  logic [63:0] cap = '0;

  // Instance A: randomized, length-checked. Instance B: plain pass-through, no length check.
  ccsds_asm_randomizer #(
    .ASM_WIDTH(32), .ASM_PATTERN(64'h1ACFFC1D), .RAND_EN(1'b1), .CW_LEN(16)
  ) dut_a (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(tready_a), .s_axis_tlast(s_tlast),
    .m_axis_tdata(tdata_a), .m_axis_tvalid(tvalid_a), .m_axis_tlast(tlast_a), .m_axis_tready(m_ready),
    .len_err(len_err_a)
  );

  ccsds_asm_randomizer #(
    .ASM_WIDTH(32), .ASM_PATTERN(64'h1ACFFC1D), .RAND_EN(1'b0), .CW_LEN(0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(tready_b), .s_axis_tlast(s_tlast),
    .m_axis_tdata(tdata_b), .m_axis_tvalid(tvalid_b), .m_axis_tlast(tlast_b), .m_axis_tready(m_ready),
    .len_err(len_err_b)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 1'b0;
      prev_le = 1'b0;
    end else begin
      if (stalled) begin
        check_eq("stall_valid", 64'(tvalid_a), 64'd1);
        check_eq("stall_data", 64'(tdata_a), 64'(held));
      end
      if (tvalid_a && m_ready) begin
        check_eq("sb_has_entry", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check_eq("data_a", 64'(tdata_a), 64'(e.a));
          check_eq("last_a", 64'(tlast_a), 64'(e.last));
          check_eq("valid_b", 64'(tvalid_b), 64'd1);
          check_eq("data_b", 64'(tdata_b), 64'(e.b));
          check_eq("last_b", 64'(tlast_b), 64'(e.last));
          if (e.cw) cap = {cap[62:0], tdata_a};
        end
        beats++;
        run_len++;
        if (tlast_a) begin
          last_idx    = beats;
          run_at_last = run_len;
        end
      end else if (!tvalid_a) begin
        run_len = 0;
      end
      stalled = tvalid_a && !m_ready;
      held    = tdata_a;
      if (len_err_a) begin
        high_cycles++;
        if (!prev_le) pulses++;
      end
      prev_le = len_err_a;
      if (len_err_b) b_err++;
    end
  end

  task automatic send_bit(input logic b, input logic last);
    int w;
    bit hs;
    s_tvalid = 1'b1;
    s_tdata  = b;
    s_tlast  = last;
    w  = 0;
    hs = 1'b0;
    while (!hs && w < 2000) begin
      @(negedge clk);
      hs = tready_a;
      @(posedge clk);
      #1;
      w++;
    end
    if (!hs) check_eq("handshake_timeout", 64'(hs), 64'd1);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    if (gap_mode && $urandom_range(0, 3) == 0) begin
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
  endtask

  task automatic push_asm();
    for (int i = 0; i < 32; i++) sb.push_back(exp_t'{asm_v[31-i], asm_v[31-i], 1'b0, 1'b0});
  endtask

  // kind: 0 = all ones, 1 = all zeros, 2 = random
  task automatic send_frame(input int n, input int kind);
    logic b;
    push_asm();
    for (int i = 0; i < n; i++) begin
      b = (kind == 0) ? 1'b1 : (kind == 1) ? 1'b0 : 1'($urandom_range(0, 1));
      sb.push_back(exp_t'{b ^ rnd_seq[i % 255], b, (i == n - 1), 1'b1});
      send_bit(b, (i == n - 1));
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((sb.size() != 0 || tvalid_a) && w < 3000) begin
      @(negedge clk);
      w++;
    end
    check_eq("drain_empty", 64'(sb.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, p0, h0;
    for (int i = 0; i < 8; i++) rnd_seq[i] = 1'b1;
    for (int i = 8; i < 255; i++) rnd_seq[i] = rnd_seq[i-1] ^ rnd_seq[i-3] ^ rnd_seq[i-5] ^ rnd_seq[i-8];

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_tvalid", 64'(tvalid_a), 64'd0);
    check_eq("rst_tdata", 64'(tdata_a), 64'd0);
    check_eq("rst_tlast", 64'(tlast_a), 64'd0);
    check_eq("rst_tready", 64'(tready_a), 64'd0);
    check_eq("rst_len_err", 64'(len_err_a), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 16 ones, 48 output beats, tlast on beat 48
    b0 = beats; p0 = pulses;
    send_frame(16, 0);
    drain();
    check_eq("t1_beats", 64'(beats - b0), 64'd48);
    check_eq("t1_last_beat", 64'(last_idx - b0), 64'd48);
    check_eq("t1_len_err", 64'(pulses - p0), 64'd0);

    // all-zero 64-bit codewords expose the raw randomizer sequence, twice
    p0 = pulses; h0 = high_cycles;
    send_frame(64, 1);
    drain();
    check_eq("rand_seq_f1", cap, 64'hFF480EC09A0D70BC);
    cap = '0;
    send_frame(64, 1);
    drain();
    check_eq("rand_seq_f2", cap, 64'hFF480EC09A0D70BC);
    check_eq("t2_len_err_pulses", 64'(pulses - p0), 64'd2);
    check_eq("t2_len_err_width", 64'(high_cycles - h0), 64'd2);

    // back-to-back frames without a bubble
    send_frame(16, 2);
    send_frame(16, 2);
    drain();
    check_eq("b2b_run", 64'(run_at_last), 64'd96);

    // random downstream stalls and upstream gaps
    p0 = pulses;
    rand_ready = 1'b1;
    gap_mode   = 1'b1;
    for (int f = 0; f < 4; f++) send_frame(16, 2);
    drain();
    rand_ready = 1'b0;
    gap_mode   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("stall_len_err", 64'(pulses - p0), 64'd0);

    // short, long, then nominal frame
    p0 = pulses; h0 = high_cycles;
    send_frame(15, 2);
    drain();
    check_eq("short_len_err", 64'(pulses - p0), 64'd1);
    b0 = beats;
    send_frame(17, 2);
    drain();
    check_eq("long_len_err", 64'(pulses - p0), 64'd2);
    check_eq("long_beats", 64'(beats - b0), 64'd49);
    send_frame(16, 2);
    drain();
    check_eq("nominal_len_err", 64'(pulses - p0), 64'd2);
    check_eq("len_err_width", 64'(high_cycles - h0), 64'd2);

    // asynchronous reset in the middle of a codeword
    push_asm();
    for (int i = 0; i < 5; i++) begin
      sb.push_back(exp_t'{1'b1 ^ rnd_seq[i], 1'b1, 1'b0, 1'b1});
      send_bit(1'b1, 1'b0);
    end
    s_tvalid = 1'b1;
    s_tdata  = 1'b1;
    #2;
    check_eq("pre_rst_valid", 64'(tvalid_a), 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_tvalid", 64'(tvalid_a), 64'd0);
    check_eq("mid_rst_tdata", 64'(tdata_a), 64'd0);
    check_eq("mid_rst_tlast", 64'(tlast_a), 64'd0);
    check_eq("mid_rst_tready", 64'(tready_a), 64'd0);
    check_eq("mid_rst_len_err", 64'(len_err_a), 64'd0);
    sb.delete();
    s_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    b0 = beats; p0 = pulses;
    send_frame(16, 2);
    drain();
    check_eq("post_rst_beats", 64'(beats - b0), 64'd48);
    check_eq("post_rst_len_err", 64'(pulses - p0), 64'd0);
    check_eq("b_len_err_never", 64'(b_err), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
